// File: rtl/clause_pkg.sv
// Shared types and default sizing for the clause shift bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clause_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Default geometry: bits per lane and lanes (literals) per clause.
    localparam int W_DEF = 8;
    localparam int C_DEF = 3;

endpackage

// File: rtl/shift_lane.sv
// One W-bit lane: parallel load, or right shift with rotate / serial fill.
// Latency: parallel load and shifts take effect on the next clock edge.
// Backpressure: shifts only when en is high; otherwise contents are held.
module shift_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         rot,
    input  logic         sin,
    input  logic         par_ld,
    input  logic [W-1:0] par_in,
    output logic [W-1:0] q,
    output logic         sout
);

    // Bit 0 is what the consumer sees; it is shifted out first.
    assign sout = q[0];

    // Load wins over shift; in rotate mode bit 0 re-enters at the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (par_ld) begin
            q <= par_in;
        end else if (en) begin
            q <= {(rot ? q[0] : sin), q[W-1:1]};
        end
    end

endmodule

// File: rtl/clause_shift_bank.sv
// C-lane clause register with a serialising burst controller (IDLE/SHIFT/DONE).
// Latency: first sout_valid one cycle after start; done one cycle after last accepted shift.
// Backpressure: sout_ready low in SHIFT stalls the lanes and the burst counter.
module clause_shift_bank
    import clause_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int C  = C_DEF,
    parameter int LW = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [C*W-1:0] par_in,
    input  logic           start,
    input  logic [LW-1:0]  len,
    input  logic           rot,
    input  logic [C-1:0]   sin,
    output logic [C-1:0]   sout,
    output logic           sout_valid,
    input  logic           sout_ready,
    output logic           busy,
    output logic           done,
    output logic [C*W-1:0] q
);

    state_e         state;
    logic [LW-1:0]  count;
    logic           rot_r;
    logic [LW-1:0]  len_clamped;
    logic           par_ld;
    logic           start_acc;
    logic           shift_en;

    // Bursts longer than a lane are pointless; clamping to W makes a full
    // rotate an identity on the stored clause.
    assign len_clamped = (len > LW'(W)) ? LW'(W) : len;

    // Load and start are only honoured when idle, and load takes priority.
    assign par_ld     = (state == IDLE) && load;
    assign start_acc  = (state == IDLE) && !load && start;
    assign shift_en   = (state == SHIFT) && sout_ready;

    assign sout_valid = (state == SHIFT);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // Burst controller: latch mode and length on start, count accepted shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            rot_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        rot_r <= rot;
                        count <= len_clamped;
                        state <= (len_clamped == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        count <= count - LW'(1);
                        if (count == LW'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One lane per literal, all shifting in lock-step.
    for (genvar i = 0; i < C; i++) begin : g_lane
        shift_lane #(
            .W (W)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .en     (shift_en),
            .rot    (rot_r),
            .sin    (sin[i]),
            .par_ld (par_ld),
            .par_in (par_in[i*W +: W]),
            .q      (q[i*W +: W]),
            .sout   (sout[i])
        );
    end

endmodule

// File: tb/tb_clause_shift_bank.sv
// Directed bench for clause_shift_bank with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised with a fixed sout_ready pattern.
module tb_clause_shift_bank;

    localparam int W  = 8;
    localparam int C  = 3;
    localparam int LW = 4;

    logic           clk;
    logic           reset;
    logic           load;
    logic [C*W-1:0] par_in;
    logic           start;
    logic [LW-1:0]  len;
    logic           rot;
    logic [C-1:0]   sin;
    logic [C-1:0]   sout;
    logic           sout_valid;
    logic           sout_ready;
    logic           busy;
    logic           done;
    logic [C*W-1:0] q;

    int tests_run = 0;
    int tests_failed = 0;

    clause_shift_bank #(.W(W), .C(C), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .par_in     (par_in),
        .start      (start),
        .len        (len),
        .rot        (rot),
        .sin        (sin),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .busy       (busy),
        .done       (done),
        .q          (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          nvalid;
    int          ndone;
    logic [7:0]  seq0;
    logic [6:0]  rdy_pat;
    logic [7:0]  exp_q0 [7];
    logic        exp_s0 [7];

    initial begin
        reset = 1'b1; load = 1'b0; par_in = '0; start = 1'b0; len = '0;
        rot = 1'b0; sin = '0; sout_ready = 1'b1;
        #12;
        // Reset state
        check("rst_q", 32'(q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_valid", 32'(sout_valid), 32'h0);
        reset = 1'b0;
        step();

        // 1: parallel load
        load = 1'b1; par_in = {8'hA5, 8'h3C, 8'hF0};
        step();
        load = 1'b0;
        check("ld_q", 32'(q), 32'hA53CF0);
        check("ld_sout", 32'(sout), 32'b100);
        check("ld_busy", 32'(busy), 32'h0);
        check("ld_done", 32'(done), 32'h0);

        // 2: rotate full lane
        start = 1'b1; len = 4'd8; rot = 1'b1; sout_ready = 1'b1;
        step();
        start = 1'b0;
        nvalid = 0; seq0 = '0;
        for (int k = 0; k < 8; k++) begin
            if (sout_valid) nvalid++;
            seq0[k] = sout[0];
            step();
        end
        check("rot_nvalid", 32'(nvalid), 32'd8);
        check("rot_seq0", 32'(seq0), 32'b11110000);
        check("rot_done", 32'(done), 32'h1);
        check("rot_valid_off", 32'(sout_valid), 32'h0);
        check("rot_q", 32'(q), 32'hA53CF0);
        step();
        check("rot_done_pulse", 32'(done), 32'h0);
        check("rot_idle", 32'(busy), 32'h0);

        // 3: serial fill with ones
        load = 1'b1; par_in = '0;
        step();
        load = 1'b0;
        start = 1'b1; len = 4'd3; rot = 1'b0; sin = 3'b111;
        step();
        start = 1'b0;
        nvalid = 0; ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (sout_valid) nvalid++;
            if (done) ndone++;
            step();
        end
        check("fill_nvalid", 32'(nvalid), 32'd3);
        check("fill_ndone", 32'(ndone), 32'd1);
        check("fill_q", 32'(q), 32'hE0E0E0);

        // 4: backpressure, ready pattern 1,0,0,1,1,0,1
        load = 1'b1; par_in = {8'h00, 8'h00, 8'hB2}; sin = 3'b000;
        step();
        load = 1'b0;
        exp_q0 = '{8'h59, 8'h59, 8'h59, 8'h2C, 8'h16, 8'h16, 8'h0B};
        exp_s0 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rdy_pat = 7'b1011001; // bit k = ready in cycle k
        start = 1'b1; len = 4'd4; rot = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            sout_ready = rdy_pat[k];
            check($sformatf("bp_valid%0d", k), 32'(sout_valid), 32'h1);
            check($sformatf("bp_sout%0d", k), 32'(sout[0]), 32'(exp_s0[k]));
            step();
            check($sformatf("bp_q%0d", k), 32'(q), 32'(exp_q0[k]));
        end
        sout_ready = 1'b1;
        check("bp_done", 32'(done), 32'h1);
        step();

        // 5a: len=0 goes straight to done
        start = 1'b1; len = 4'd0;
        step();
        start = 1'b0;
        check("len0_done", 32'(done), 32'h1);
        check("len0_valid", 32'(sout_valid), 32'h0);
        check("len0_q", 32'(q), 32'h00000B);
        step();
        check("len0_idle", 32'(busy), 32'h0);

        // 5b: len=15 clamps to 8 rotates
        load = 1'b1; par_in = {8'hA5, 8'h3C, 8'hF0};
        step();
        load = 1'b0;
        start = 1'b1; len = 4'd15; rot = 1'b1;
        step();
        start = 1'b0;
        nvalid = 0; ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (sout_valid) nvalid++;
            if (done) ndone++;
            step();
        end
        check("clamp_nvalid", 32'(nvalid), 32'd8);
        check("clamp_ndone", 32'(ndone), 32'd1);
        check("clamp_q", 32'(q), 32'hA53CF0);

        // 5c: load and start together -> load only
        load = 1'b1; start = 1'b1; len = 4'd2; par_in = {8'h11, 8'h22, 8'h33};
        step();
        load = 1'b0; start = 1'b0;
        check("ldst_q", 32'(q), 32'h112233);
        check("ldst_busy", 32'(busy), 32'h0);
        step();
        check("ldst_valid", 32'(sout_valid), 32'h0);

        // 5d: load during SHIFT ignored
        start = 1'b1; len = 4'd2; rot = 1'b1;
        step();
        start = 1'b0;
        load = 1'b1; par_in = 24'hFFFFFF;
        step();
        step();
        check("ldsh_done", 32'(done), 32'h1);
        load = 1'b0;
        check("ldsh_q", 32'(q), 32'h4488CC);
        step();

        // 6: async reset mid-burst
        load = 1'b1; par_in = {8'hA5, 8'h3C, 8'hF0};
        step();
        load = 1'b0;
        start = 1'b1; len = 4'd8; rot = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_valid", 32'(sout_valid), 32'h0);
        step();
        check("arst_nodone", 32'(done), 32'h0);
        reset = 1'b0;
        step();
        check("arst_nodone2", 32'(done), 32'h0);
        load = 1'b1; par_in = {8'h00, 8'h00, 8'hF0};
        step();
        load = 1'b0;
        start = 1'b1; len = 4'd1; rot = 1'b0; sin = 3'b001;
        step();
        start = 1'b0;
        check("post_valid", 32'(sout_valid), 32'h1);
        step();
        check("post_done", 32'(done), 32'h1);
        check("post_q", 32'(q), 32'h0000F8);
        step();
        check("post_idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clause_shift_bank.md
Name: clause_shift_bank

Overview:
- Multi-lane, parametrised clause storage shift register with a serialising controller.
- C lanes (one per literal of a clause), each W bits, shift in lock-step.
- Supports parallel load, programmable-length serial shift-out with valid/ready handshake, and rotate mode that preserves contents.
- Feeds clause bits serially to the evaluation datapath and accepts serial refill.

Parameters:
W, 8, bits per lane
C, 3, number of lanes (literals per clause)
LW, $clog2(W+1), width of shift-length field

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
load  in  1  parallel-load strobe (honoured only in IDLE)
par_in  in  C*W  parallel data; lane i = par_in[i*W +: W]
start  in  1  begin a shift burst (honoured only in IDLE)
len  in  LW  number of shifts in burst; sampled on accepted start
rot  in  1  1 = rotate (bit0 re-enters at MSB), 0 = shift in sin; sampled on accepted start
sin  in  C  serial input, one bit per lane
sout  out  C  serial output; sout[i] = lane i bit 0, combinational from q
sout_valid  out  1  high in SHIFT state
sout_ready  in  1  consumer accepts current sout
busy  out  1  high in SHIFT or DONE
done  out  1  one-cycle pulse at end of burst
q  out  C*W  full register contents

Behaviour:
- Reset (async): q = 0, state = IDLE, count = 0, rot_r = 0; sout_valid = 0, busy = 0, done = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load=1: q <= par_in next edge; start is ignored that cycle (load has priority).
  - start=1 and load=0: latch rot_r <= rot and count <= min(len, W).
    - If the clamped count is 0, go to DONE.
    - Otherwise go to SHIFT.
- SHIFT:
  - sout_valid = 1.
  - Shift occurs only on the sout_valid & sout_ready edge: each lane i <= {rot_r ? lane[0] : sin[i], lane[W-1:1]}; count <= count-1.
  - When a shift is accepted with count==1, go to DONE.
  - ready=0 stalls: q, count and sout are held.
  - load and start are ignored.
- DONE: done = 1 for exactly one cycle; next state IDLE; load and start are ignored.
- Latency:
  - start accepted -> first sout_valid on the next cycle.
  - Last accepted shift -> done on the next cycle.
  - Minimum burst of len shifts = len+2 cycles, including start and done.
  - len=0 -> done 1 cycle after start.
- len > W is clamped to W, so rotate with len=W restores the original contents.
- Reset mid-SHIFT: immediate return to IDLE, q cleared, no done pulse.
- sin is sampled only on accepted shifts; its value is a don't-care in rotate mode.
- No arithmetic overflow is possible: count never decrements below 0; it is only decremented in SHIFT, where count is at least 1.

Decomposition:
- Shared package clause_pkg: state enum {IDLE, SHIFT, DONE}; default W and C constants.
- Sub-module shift_lane (W param): one lane with inputs en, rot, sin, par_ld, par_in and outputs q, sout; instantiated C times.
- Controller FSM and counter live in clause_shift_bank.

Test Plan:
1. Reset, then load=1 with par_in={8'hA5,8'h3C,8'hF0} -> next cycle q matches par_in; sout=3'b{1,0,0} (lane2,1,0); busy=0, done=0.
2. From state 1: start, len=8, rot=1, ready=1 constantly -> sout_valid high for 8 cycles.
   - lane0 sout sequence 0,0,0,0,1,1,1,1.
   - done pulses 1 cycle; q returns to the loaded value.
3. q=0, start len=3, rot=0, sin=3'b111 each shift -> after done each lane = 8'hE0; sout_valid asserted exactly 3 cycles.
4. Backpressure: start len=4, ready toggled 1,0,0,1,1,0,1 -> exactly 4 shifts occur, only on ready=1 cycles; q and sout are held during stalls; done follows the 4th accept.
5. Boundaries:
   - len=0 -> done 1 cycle after start, q unchanged.
   - len=15 -> clamped to 8 shifts.
   - load and start asserted together in IDLE -> load only, no burst.
   - load during SHIFT -> ignored.
6. Assert reset after 2 of 8 shifts -> q=0 and state IDLE immediately (async); no done pulse; a subsequent start works normally.
